// File: rtl/ex_stage.sv
// Execute stage: single-cycle ALU, iterative 32-cycle shift-add multiplier for MUL/MULHU,
// and the EX/MEM pipeline register feeding the memory stage.
module ex_stage #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            valid_in,
    input  logic            flush,
    input  logic [3:0]      alu_op,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    input  logic [XLEN-1:0] reg_out_b_in,
    input  logic [XLEN-1:0] add_pc_in,
    input  logic            mem_we_in,
    input  logic            mem_re_in,
    input  logic            branch_instruction_in,
    input  logic            reg_file_write_in,
    input  logic [1:0]      select_mux_4_in,
    input  logic [1:0]      select_mux_2_in,
    output logic            stall,
    output logic [XLEN-1:0] alu_out,
    output logic            branch_out,
    output logic [XLEN-1:0] reg_out_b,
    output logic [XLEN-1:0] add_pc_out,
    output logic            mem_we,
    output logic            mem_re,
    output logic            branch_instruction,
    output logic            reg_file_write_out,
    output logic [1:0]      select_mux_4_out,
    output logic [1:0]      select_mux_2_out
);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] BUSY = 1'b1;
    localparam logic [4:0] LAST = 5'd31;

    logic [0:0]        state;
    logic [4:0]        count;
    logic [2*XLEN-1:0] acc;
    logic [2*XLEN-1:0] acc_next;
    logic [2*XLEN-1:0] mul_addend;
    logic [XLEN-1:0]   mcand;
    logic [XLEN-1:0]   mplier;
    logic              cap_hi;
    logic [XLEN-1:0]   cap_rob;
    logic [XLEN-1:0]   cap_pc;
    logic              cap_we;
    logic              cap_re;
    logic              cap_br;
    logic              cap_rfw;
    logic [1:0]        cap_m4;
    logic [1:0]        cap_m2;

    logic              is_mul;
    logic              issue;
    logic              last_cycle;
    logic [XLEN-1:0]   alu_result;

    logic [XLEN-1:0]   nxt_alu;
    logic              nxt_branch;
    logic [XLEN-1:0]   nxt_rob;
    logic [XLEN-1:0]   nxt_pc;
    logic              nxt_we;
    logic              nxt_re;
    logic              nxt_br;
    logic              nxt_rfw;
    logic [1:0]        nxt_m4;
    logic [1:0]        nxt_m2;

    assign is_mul     = (alu_op == 4'd10) || (alu_op == 4'd11);
    assign issue      = !flush && (state == IDLE) && valid_in && is_mul;
    assign last_cycle = (state == BUSY) && (count == LAST);
    assign stall      = issue || (!flush && (state == BUSY) && (count != LAST));

    always_comb begin
        alu_result = '0;
        case (alu_op)
            4'd0: alu_result = op_a + op_b;
            4'd1: alu_result = op_a - op_b;
            4'd2: alu_result = op_a & op_b;
            4'd3: alu_result = op_a | op_b;
            4'd4: alu_result = op_a ^ op_b;
            4'd5: alu_result = op_a << op_b[4:0];
            4'd6: alu_result = op_a >> op_b[4:0];
            4'd7: alu_result = $signed(op_a) >>> op_b[4:0];
            4'd8: alu_result[0] = $signed(op_a) < $signed(op_b);
            4'd9: alu_result[0] = op_a < op_b;
            default: alu_result = '0;
        endcase
    end

    always_comb begin
        mul_addend = '0;
        if (mplier[count])
            mul_addend = {{XLEN{1'b0}}, mcand} << count;
        acc_next = acc + mul_addend;
    end

    // EX/MEM next value: bubble unless a single-cycle op issues or the multiply completes.
    always_comb begin
        nxt_alu    = '0;
        nxt_branch = 1'b0;
        nxt_rob    = '0;
        nxt_pc     = '0;
        nxt_we     = 1'b0;
        nxt_re     = 1'b0;
        nxt_br     = 1'b0;
        nxt_rfw    = 1'b0;
        nxt_m4     = '0;
        nxt_m2     = '0;
        if (!flush) begin
            if ((state == IDLE) && valid_in && !is_mul) begin
                nxt_alu    = alu_result;
                nxt_branch = (alu_result == '0);
                nxt_rob    = reg_out_b_in;
                nxt_pc     = add_pc_in;
                nxt_we     = mem_we_in;
                nxt_re     = mem_re_in;
                nxt_br     = branch_instruction_in;
                nxt_rfw    = reg_file_write_in;
                nxt_m4     = select_mux_4_in;
                nxt_m2     = select_mux_2_in;
            end else if (last_cycle) begin
                nxt_alu    = cap_hi ? acc_next[2*XLEN-1:XLEN] : acc_next[XLEN-1:0];
                nxt_branch = (nxt_alu == '0);
                nxt_rob    = cap_rob;
                nxt_pc     = cap_pc;
                nxt_we     = cap_we;
                nxt_re     = cap_re;
                nxt_br     = cap_br;
                nxt_rfw    = cap_rfw;
                nxt_m4     = cap_m4;
                nxt_m2     = cap_m2;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state   <= IDLE;
            count   <= '0;
            acc     <= '0;
            mcand   <= '0;
            mplier  <= '0;
            cap_hi  <= 1'b0;
            cap_rob <= '0;
            cap_pc  <= '0;
            cap_we  <= 1'b0;
            cap_re  <= 1'b0;
            cap_br  <= 1'b0;
            cap_rfw <= 1'b0;
            cap_m4  <= '0;
            cap_m2  <= '0;
        end else if (flush) begin
            state <= IDLE;
            count <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (issue) begin
                        state   <= BUSY;
                        count   <= '0;
                        acc     <= '0;
                        mcand   <= op_a;
                        mplier  <= op_b;
                        cap_hi  <= (alu_op == 4'd11);
                        cap_rob <= reg_out_b_in;
                        cap_pc  <= add_pc_in;
                        cap_we  <= mem_we_in;
                        cap_re  <= mem_re_in;
                        cap_br  <= branch_instruction_in;
                        cap_rfw <= reg_file_write_in;
                        cap_m4  <= select_mux_4_in;
                        cap_m2  <= select_mux_2_in;
                    end
                end
                default: begin
                    acc   <= acc_next;
                    count <= count + 5'd1;
                    if (count == LAST)
                        state <= IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            alu_out            <= '0;
            branch_out         <= 1'b0;
            reg_out_b          <= '0;
            add_pc_out         <= '0;
            mem_we             <= 1'b0;
            mem_re             <= 1'b0;
            branch_instruction <= 1'b0;
            reg_file_write_out <= 1'b0;
            select_mux_4_out   <= '0;
            select_mux_2_out   <= '0;
        end else begin
            alu_out            <= nxt_alu;
            branch_out         <= nxt_branch;
            reg_out_b          <= nxt_rob;
            add_pc_out         <= nxt_pc;
            mem_we             <= nxt_we;
            mem_re             <= nxt_re;
            branch_instruction <= nxt_br;
            reg_file_write_out <= nxt_rfw;
            select_mux_4_out   <= nxt_m4;
            select_mux_2_out   <= nxt_m2;
        end
    end

endmodule
